// File: rtl/run_stuff_tx.sv
// Serial frame transmitter: sends a DATA_W-bit payload MSB first, inserting a complement bit
// after every run of two equal bits, and closes each frame with a 1,1,1 delimiter.
// Optional even-parity bit after the payload when RUN_STUFF_TX_PARITY_EN is defined.
module run_stuff_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              serial_out,
    output logic              tx_active,
    output logic              stuff_bit
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // The state names what is currently on serial_out, so it moves with the registered outputs.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        STUFF = 3'd2,
`ifdef RUN_STUFF_TX_PARITY_EN
        PAR   = 3'd3,
`endif
        DELIM = 3'd4
    } state_t;

    state_t             state, stateNext;
    logic [DATA_W-1:0]  shreg, shregNext;
    logic [CNT_W-1:0]   remaining, remainingNext;
    logic               lastBit, lastBitNext;
    logic               runTwo, runTwoNext;
    logic [1:0]         delimCnt, delimCntNext;
    logic               serialNext, activeNext, stuffNext;
    logic               dataBit;
`ifdef RUN_STUFF_TX_PARITY_EN
    logic               parBit, parBitNext;
    logic               parDone, parDoneNext;
`endif

    assign ready_out = (state == IDLE);
    assign dataBit   = shreg[DATA_W-2];

    // Next-bit selection: a pending run of two always wins, then payload, parity, delimiter.
    always_comb begin
        stateNext     = state;
        shregNext     = shreg;
        remainingNext = remaining;
        lastBitNext   = lastBit;
        runTwoNext    = runTwo;
        delimCntNext  = delimCnt;
        serialNext    = 1'b0;
`ifdef RUN_STUFF_TX_PARITY_EN
        parBitNext    = parBit;
        parDoneNext   = parDone;
`endif
        case (state)
            IDLE: begin
                if (valid_in) begin
                    stateNext     = DATA;
                    shregNext     = data_in;
                    remainingNext = CNT_W'(DATA_W - 1);
                    serialNext    = data_in[DATA_W-1];
                    lastBitNext   = data_in[DATA_W-1];
                    runTwoNext    = 1'b0;
`ifdef RUN_STUFF_TX_PARITY_EN
                    parBitNext    = ^data_in;
                    parDoneNext   = 1'b0;
`endif
                end
            end
            DELIM: begin
                if (delimCnt == 2'd2) begin
                    stateNext = IDLE;
                end else begin
                    serialNext   = 1'b1;
                    delimCntNext = delimCnt + 2'd1;
                end
            end
            default: begin
                if (runTwo) begin
                    stateNext   = STUFF;
                    serialNext  = ~lastBit;
                    lastBitNext = ~lastBit;
                    runTwoNext  = 1'b0;
                end else if (remaining != '0) begin
                    stateNext     = DATA;
                    shregNext     = shreg << 1;
                    remainingNext = remaining - CNT_W'(1);
                    serialNext    = dataBit;
                    lastBitNext   = dataBit;
                    runTwoNext    = (dataBit == lastBit);
`ifdef RUN_STUFF_TX_PARITY_EN
                end else if (!parDone) begin
                    stateNext   = PAR;
                    serialNext  = parBit;
                    lastBitNext = parBit;
                    runTwoNext  = (parBit == lastBit);
                    parDoneNext = 1'b1;
`endif
                end else begin
                    stateNext    = DELIM;
                    serialNext   = 1'b1;
                    delimCntNext = 2'd0;
                end
            end
        endcase
        activeNext = (stateNext != IDLE);
        stuffNext  = (stateNext == STUFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            remaining  <= '0;
            lastBit    <= 1'b0;
            runTwo     <= 1'b0;
            delimCnt   <= 2'd0;
            serial_out <= 1'b0;
            tx_active  <= 1'b0;
            stuff_bit  <= 1'b0;
`ifdef RUN_STUFF_TX_PARITY_EN
            parBit     <= 1'b0;
            parDone    <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            shreg      <= shregNext;
            remaining  <= remainingNext;
            lastBit    <= lastBitNext;
            runTwo     <= runTwoNext;
            delimCnt   <= delimCntNext;
            serial_out <= serialNext;
            tx_active  <= activeNext;
            stuff_bit  <= stuffNext;
`ifdef RUN_STUFF_TX_PARITY_EN
            parBit     <= parBitNext;
            parDone    <= parDoneNext;
`endif
        end
    end

endmodule

// File: tb/tb_run_stuff_tx.sv
// Self-checking bench for run_stuff_tx: directed and random payloads compared against a
// queue-based frame model; honours RUN_STUFF_TX_PARITY_EN the same way as the design.
module tb_run_stuff_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       serial_out;
    logic       tx_active;
    logic       stuff_bit;

    int checks = 0;
    int errors = 0;
    bit expBits[$];
    bit expStuff[$];

    run_stuff_tx #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .serial_out (serial_out),
        .tx_active  (tx_active),
        .stuff_bit  (stuff_bit)
    );

    always #5 clk = ~clk;

    // Builds the expected line bits of one frame from the bit-stuffing rules.
    function automatic void buildExpected(input logic [7:0] p);
        bit content[$];
        int run;
        bit last;
        expBits.delete();
        expStuff.delete();
        for (int i = 7; i >= 0; i--) content.push_back(p[i]);
`ifdef RUN_STUFF_TX_PARITY_EN
        content.push_back(^p);
`endif
        run  = 0;
        last = 1'b0;
        foreach (content[k]) begin
            expBits.push_back(content[k]);
            expStuff.push_back(1'b0);
            run  = (run > 0 && content[k] == last) ? run + 1 : 1;
            last = content[k];
            if (run == 2) begin
                expBits.push_back(!last);
                expStuff.push_back(1'b1);
                last = !last;
                run  = 1;
            end
        end
        repeat (3) begin
            expBits.push_back(1'b1);
            expStuff.push_back(1'b0);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the DUT to be idle, then offers a payload.
    task automatic applyStimulus(input logic [7:0] p);
        int n;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n = 0;
        while (ready_out !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyWait", ready_out, 1'b1);
        data_in  = p;
        valid_in = 1'b1;
    endtask

    // Checks one full frame plus the idle cycle after it; optionally keeps valid_in high with junk.
    task automatic runFrame(input logic [7:0] p, input bit junk, input bit chain, input logic [7:0] nextP);
        buildExpected(p);
        for (int i = 0; i < expBits.size(); i++) begin
            @(negedge clk);
            if (junk) data_in = 8'($urandom);
            else valid_in = 1'b0;
            checkOutput($sformatf("serial[%02h:%0d]", p, i), serial_out, expBits[i]);
            checkOutput($sformatf("stuff[%02h:%0d]", p, i), stuff_bit, expStuff[i]);
            checkOutput($sformatf("active[%02h:%0d]", p, i), tx_active, 1'b1);
            checkOutput($sformatf("ready[%02h:%0d]", p, i), ready_out, 1'b0);
        end
        @(negedge clk);
        checkOutput($sformatf("idleActive[%02h]", p), tx_active, 1'b0);
        checkOutput($sformatf("idleSerial[%02h]", p), serial_out, 1'b0);
        checkOutput($sformatf("idleStuff[%02h]", p), stuff_bit, 1'b0);
        checkOutput($sformatf("idleReady[%02h]", p), ready_out, 1'b1);
        if (chain) begin
            data_in  = nextP;
            valid_in = 1'b1;
        end else begin
            valid_in = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] p;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rstSerial", serial_out, 1'b0);
        checkOutput("rstActive", tx_active, 1'b0);
        checkOutput("rstStuff", stuff_bit, 1'b0);
        checkOutput("rstReady", ready_out, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("readyAfterRelease", ready_out, 1'b1);

        applyStimulus(8'hAA); runFrame(8'hAA, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h00); runFrame(8'h00, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'hCC); runFrame(8'hCC, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'hFF); runFrame(8'hFF, 1'b0, 1'b0, 8'h00);
        applyStimulus(8'h01); runFrame(8'h01, 1'b0, 1'b0, 8'h00);

        // Abort a 0x00 frame in its fourth cycle, then send 0xAA cleanly.
        applyStimulus(8'h00);
        buildExpected(8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
            checkOutput($sformatf("abortSerial[%0d]", i), serial_out, expBits[i]);
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("abortSerialRst", serial_out, 1'b0);
        checkOutput("abortActiveRst", tx_active, 1'b0);
        checkOutput("abortStuffRst", stuff_bit, 1'b0);
        checkOutput("abortReadyRst", ready_out, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'hAA); runFrame(8'hAA, 1'b0, 1'b0, 8'h00);

        // valid_in held high with changing data: next capture only on the idle cycle.
        applyStimulus(8'h5A);
        runFrame(8'h5A, 1'b1, 1'b1, 8'h3C);
        runFrame(8'h3C, 1'b0, 1'b0, 8'h00);

        repeat (20) begin
            p = 8'($urandom);
            applyStimulus(p);
            runFrame(p, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
